// File: rtl/alu_issue_buffer_pkg.sv
// alu_issue_buffer_pkg: opcode and FSM state encodings shared by the ALU issue buffer files.
package alu_issue_buffer_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [2:0] {ALU_ADD, ALU_AND, ALU_OR, ALU_SUB, ALU_MUL, ALU_SLT} alu_op_e;
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_e;
  function automatic logic op_legal(input logic [2:0] op);
    return op <= ALU_SLT;
  endfunction
endpackage

// File: rtl/alu_issue_buffer_if.sv
// alu_issue_buffer_if: request and result handshake bundle of the ALU issue buffer.
interface alu_issue_buffer_if #(parameter int WIDTH = 32, parameter int TAGW = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_zf;
  logic [TAGW-1:0]  out_tag;
  logic             out_err;
  modport slave (input in_valid, in_a, in_b, in_op, in_tag, out_ready,
                 output in_ready, out_valid, out_res, out_zf, out_tag, out_err);
  modport master (output in_valid, in_a, in_b, in_op, in_tag, out_ready,
                  input in_ready, out_valid, out_res, out_zf, out_tag, out_err);
endinterface

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: DEPTH-entry synchronous request FIFO with occupancy count; caller never overflows or underflows it.
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int PW = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [PW-1:0] wdata_i,
  output logic [PW-1:0] rdata_o,
  output logic [CW-1:0] count_o
);
  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: queues ALU requests, drives one op per evaluating edge and returns the captured result with its tag.
// Optional ALU_OP_CHECK_EN: ops 110/111 bypass the ALU and return out_err=1 with a zero result.
module alu_issue_buffer
  import alu_issue_buffer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter int TAGW = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  alu_issue_buffer_if.slave bus,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_res_i,
  input  logic             alu_zf_i,
  output logic [CW-1:0]    count_o
);
  localparam int PW = 3 + TAGW + 2 * WIDTH;
  state_e state_q, state_d;
  logic [PW-1:0] head;
  logic [2:0] head_op;
  logic [TAGW-1:0] head_tag;
  logic [WIDTH-1:0] head_a, head_b;
  logic push, pop, hs, legal, issue, cap;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, out_res_q, out_res_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [TAGW-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
  logic err_q, err_d, out_valid_q, out_valid_d, out_zf_q, out_zf_d, out_err_q, out_err_d;

  alu_req_fifo #(.DEPTH(DEPTH), .PW(PW)) u_fifo (
    .clk_i, .rst_ni, .push_i(push), .pop_i(pop),
    .wdata_i({bus.in_op, bus.in_tag, bus.in_b, bus.in_a}),
    .rdata_o(head), .count_o
  );
  assign {head_op, head_tag, head_b, head_a} = head;

`ifdef ALU_OP_CHECK_EN
  assign legal = op_legal(head_op);
`else
  assign legal = 1'b1;
`endif

  assign bus.in_ready = count_o != CW'(DEPTH);
  assign push = bus.in_valid & bus.in_ready;
  assign hs = out_valid_q & bus.out_ready;
  assign pop = (count_o != '0) & ((state_q == IDLE) | (state_q == HOLD & hs));
  assign issue = pop & legal;
  assign cap = state_q == CAPTURE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Illegal ops skip DRIVE: nothing reaches the ALU, CAPTURE just reports the error.
  always_comb begin
    state_d = pop ? (legal ? DRIVE : CAPTURE) :
              state_q == DRIVE   ? CAPTURE :
              state_q == CAPTURE ? HOLD :
              (state_q == HOLD && hs) ? IDLE : state_q;
  end

  always_comb begin
    alu_a_d     = issue ? head_a : alu_a_q;
    alu_b_d     = issue ? head_b : alu_b_q;
    alu_op_d    = issue ? head_op : alu_op_q;
    tag_d       = pop ? head_tag : tag_q;
    err_d       = pop ? ~legal : err_q;
    out_valid_d = cap | (out_valid_q & ~hs);
    out_res_d   = cap ? (err_q ? '0 : alu_res_i) : out_res_q;
    out_zf_d    = cap ? (~err_q & alu_zf_i) : out_zf_q;
    out_tag_d   = cap ? tag_q : out_tag_q;
    out_err_d   = cap ? err_q : out_err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= ALU_ADD;
      tag_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_zf_q    <= 1'b0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_zf_q    <= out_zf_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
    end
  end

  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_op_o      = alu_op_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_zf    = out_zf_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_alu_issue_buffer.sv
// tb_alu_issue_buffer: scoreboard bench for alu_issue_buffer with a registered 32-bit ALU model.
module tb_alu_issue_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_buffer_if #(.WIDTH(32), .TAGW(4)) bus();
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_op, count;
  logic alu_zf;

  alu_issue_buffer #(.WIDTH(32), .DEPTH(4), .TAGW(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_res_i(alu_res), .alu_zf_i(alu_zf), .count_o(count)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a - b;
      3'd4: return a * b;
      3'd5: return {31'b0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_res <= alu_f(alu_a, alu_b, alu_op);
    alu_zf  <= alu_f(alu_a, alu_b, alu_op) == 32'd0;
  end

  typedef struct packed {logic [31:0] res; logic zf; logic [3:0] tag; logic err;} exp_t;
  exp_t sb[$];
  int passed = 0, total = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ALU_OP_CHECK_EN
  localparam logic ILL_ZF = 1'b0, ILL_ERR = 1'b1;
  localparam logic [2:0] ILL_ALU_OP = 3'b010;
`else
  localparam logic ILL_ZF = 1'b1, ILL_ERR = 1'b0;
  localparam logic [2:0] ILL_ALU_OP = 3'b111;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got tag %0d expected no result", bus.out_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("res tag%0d", e.tag), 64'(bus.out_res), 64'(e.res));
        chk($sformatf("zf tag%0d", e.tag), 64'(bus.out_zf), 64'(e.zf));
        chk($sformatf("tag tag%0d", e.tag), 64'(bus.out_tag), 64'(e.tag));
        chk($sformatf("err tag%0d", e.tag), 64'(bus.out_err), 64'(e.err));
      end
    end
  end

  task automatic push(input logic [31:0] a, b, input logic [2:0] op, input logic [3:0] tag,
                      input logic [31:0] er, input logic ez, input logic ee);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 (tag %0d)", tag);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    bus.in_tag = tag;
    sb.push_back('{er, ez, tag, ee});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      $display("FAIL valid_timeout: got out_valid 0 expected 1");
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bus.out_valid || count != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 bus.out_ready = r;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, t[5];
    logic seen;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_op = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_res", 64'(bus.out_res), 64'd0);
    chk("rst_out_tag_zf_err", 64'({bus.out_tag, bus.out_zf, bus.out_err}), 64'd0);
    chk("rst_alu", 64'({alu_a, alu_op}), 64'd0);
    #10 rst_n = 1'b1;

    // single ADD, latency of three edges from the accepting edge
    push(32'd5, 32'd3, 3'b000, 4'd1, 32'd8, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 64'(n), 64'd3);
    drain();

    push(32'd7, 32'd7, 3'b011, 4'd2, 32'd0, 1'b1, 1'b0);
    push(32'd2, 32'd9, 3'b101, 4'd3, 32'd1, 1'b0, 1'b0);
    push(32'd6, 32'd7, 3'b100, 4'd4, 32'd42, 1'b0, 1'b0);
    push(32'h0000_f0f0, 32'h0000_ff00, 3'b001, 4'd5, 32'h0000_f000, 1'b0, 1'b0);
    push(32'h0f, 32'hf0, 3'b010, 4'd6, 32'hff, 1'b0, 1'b0);
    push(32'hffff_ffff, 32'd1, 3'b101, 4'd7, 32'd0, 1'b1, 1'b0);
    push(32'hffff_ffff, 32'd1, 3'b000, 4'd8, 32'd0, 1'b1, 1'b0);
    drain();

    // fill: one in flight plus four queued
    set_ready(1'b0);
    push(32'd1, 32'd1, 3'b000, 4'd0, 32'd2, 1'b0, 1'b0);
    push(32'd10, 32'd3, 3'b011, 4'd1, 32'd7, 1'b0, 1'b0);
    push(32'd3, 32'd5, 3'b100, 4'd2, 32'd15, 1'b0, 1'b0);
    push(32'd8, 32'd1, 3'b010, 4'd3, 32'd9, 1'b0, 1'b0);
    push(32'd12, 32'd10, 3'b001, 4'd4, 32'd8, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    wait_valid();
    repeat (4) @(negedge clk);
    chk("hold_valid", 64'(bus.out_valid), 64'd1);
    chk("hold_tag_res", 64'({bus.out_tag, bus.out_res}), 64'({4'd0, 32'd2}));
    set_ready(1'b1);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      @(negedge clk);
      while (!(bus.out_valid && bus.out_ready) && n < 50) begin
        @(negedge clk);
        n++;
      end
      t[k] = cyc;
    end
    for (int k = 1; k < 5; k++) chk($sformatf("rate%0d", k), 64'(t[k] - t[k-1]), 64'd3);
    drain();

    // simultaneous push and pop at count 2
    set_ready(1'b0);
    push(32'd10, 32'd0, 3'b000, 4'd10, 32'd10, 1'b0, 1'b0);
    push(32'd11, 32'd0, 3'b000, 4'd11, 32'd11, 1'b0, 1'b0);
    push(32'd12, 32'd0, 3'b000, 4'd12, 32'd12, 1'b0, 1'b0);
    wait_valid();
    chk("pre_count", 64'(count), 64'd2);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 32'd13;
    bus.in_b = 32'd0;
    bus.in_op = 3'b000;
    bus.in_tag = 4'd13;
    sb.push_back('{32'd13, 1'b0, 4'd13, 1'b0});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("pushpop_count", 64'(count), 64'd2);
    for (int i = 0; i < 10; i++)
      push(32'h100 * i, i, 3'b000, 4'(i), 32'h101 * i, i == 0, 1'b0);
    drain();

    // illegal opcode
    push(32'd3, 32'd4, 3'b010, 4'd9, 32'd7, 1'b0, 1'b0);
    push(32'd9, 32'd4, 3'b111, 4'd3, 32'd0, ILL_ZF, ILL_ERR);
    drain();
    chk("illegal_alu_op", 64'(alu_op), 64'(ILL_ALU_OP));

    // asynchronous reset while holding a result with one request queued
    set_ready(1'b0);
    push(32'd6, 32'd7, 3'b100, 4'd1, 32'd42, 1'b0, 1'b0);
    push(32'd1, 32'd2, 3'b000, 4'd2, 32'd3, 1'b0, 1'b0);
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_alu_op", 64'(alu_op), 64'd0);
    chk("async_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    chk("no_result_after_reset", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
